// File: rtl/pwm_cfg_loader.sv
// Loads a latched PWM configuration snapshot into the register file over
// its byte bus, then optionally verifies it and enables the counter.
// While a load runs the host bus is stalled and its accesses are dropped.
// Ports: clk/rst; start + cfg_* snapshot inputs; busy/done/error status;
// host_* side of the bus; read/write/addr/data_write/data_read to regfile.
module pwm_cfg_loader #(
  parameter bit VERIFY_EN   = 1'b1,
  parameter bit AUTO_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_compare1,
  input  logic [15:0] cfg_compare2,
  input  logic [7:0]  cfg_prescale,
  input  logic [7:0]  cfg_functions,
  input  logic        cfg_upnotdown,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [5:0]  host_addr,
  input  logic [7:0]  host_data_write,
  output logic [7:0]  host_data_read,
  output logic        host_stall,
  output logic        read,
  output logic        write,
  output logic [5:0]  addr,
  output logic [7:0]  data_write,
  input  logic [7:0]  data_read
);

  typedef enum logic [2:0] {IDLE, WR_CFG, VERIFY, ENABLE, FIN} state_t;

  state_t      state;
  logic [3:0]  step;
  logic [3:0]  step_nxt;
  logic [15:0] snap_period, snap_cmp1, snap_cmp2;
  logic [7:0]  snap_prescale, snap_functions;
  logic        snap_upnotdown;
  logic        seq_read, seq_write;
  logic [5:0]  seq_addr;
  logic [7:0]  seq_data;
  logic [13:0] cfg_wr_nxt;
  logic [5:0]  vr_addr_nxt;
  logic [7:0]  vr_exp;
  logic        mismatch;

  assign step_nxt = step + 4'd1;

  // Bus outputs are registered, so each transition loads the access for
  // the step being entered; these tables are indexed by that next step.
  always_comb begin
    cfg_wr_nxt = '0;
    unique case (step_nxt)
      4'd1:    cfg_wr_nxt = {6'h0C, 8'h00};
      4'd2:    cfg_wr_nxt = {6'h00, snap_period[7:0]};
      4'd3:    cfg_wr_nxt = {6'h01, snap_period[15:8]};
      4'd4:    cfg_wr_nxt = {6'h03, snap_cmp1[7:0]};
      4'd5:    cfg_wr_nxt = {6'h04, snap_cmp1[15:8]};
      4'd6:    cfg_wr_nxt = {6'h05, snap_cmp2[7:0]};
      4'd7:    cfg_wr_nxt = {6'h06, snap_cmp2[15:8]};
      4'd8:    cfg_wr_nxt = {6'h0A, snap_prescale};
      4'd9:    cfg_wr_nxt = {6'h0B, 7'b0, snap_upnotdown};
      4'd10:   cfg_wr_nxt = {6'h0D, snap_functions};
      4'd11:   cfg_wr_nxt = {6'h07, 8'h01};
      default: cfg_wr_nxt = '0;
    endcase
  end

  always_comb begin
    vr_addr_nxt = '0;
    unique case (step_nxt)
      4'd1:    vr_addr_nxt = 6'h01;
      4'd2:    vr_addr_nxt = 6'h03;
      4'd3:    vr_addr_nxt = 6'h04;
      4'd4:    vr_addr_nxt = 6'h05;
      4'd5:    vr_addr_nxt = 6'h06;
      4'd6:    vr_addr_nxt = 6'h0A;
      4'd7:    vr_addr_nxt = 6'h0B;
      4'd8:    vr_addr_nxt = 6'h0D;
      default: vr_addr_nxt = 6'h00;
    endcase
  end

  always_comb begin
    vr_exp = '0;
    unique case (seq_addr)
      6'h00:   vr_exp = snap_period[7:0];
      6'h01:   vr_exp = snap_period[15:8];
      6'h03:   vr_exp = snap_cmp1[7:0];
      6'h04:   vr_exp = snap_cmp1[15:8];
      6'h05:   vr_exp = snap_cmp2[7:0];
      6'h06:   vr_exp = snap_cmp2[15:8];
      6'h0A:   vr_exp = snap_prescale;
      6'h0B:   vr_exp = {7'b0, snap_upnotdown};
      6'h0D:   vr_exp = snap_functions;
      default: vr_exp = '0;
    endcase
  end

  assign mismatch = (data_read != vr_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      step           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      snap_period    <= '0;
      snap_cmp1      <= '0;
      snap_cmp2      <= '0;
      snap_prescale  <= '0;
      snap_functions <= '0;
      snap_upnotdown <= 1'b0;
      seq_read       <= 1'b0;
      seq_write      <= 1'b0;
      seq_addr       <= '0;
      seq_data       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap_period    <= cfg_period;
            snap_cmp1      <= cfg_compare1;
            snap_cmp2      <= cfg_compare2;
            snap_prescale  <= cfg_prescale;
            snap_functions <= cfg_functions;
            snap_upnotdown <= cfg_upnotdown;
            error          <= 1'b0;
            busy           <= 1'b1;
            step           <= '0;
            state          <= WR_CFG;
            seq_read       <= 1'b0;
            seq_write      <= 1'b1;
            seq_addr       <= 6'h02;
            seq_data       <= 8'h00;
          end
        end
        WR_CFG: begin
          if (step == 4'd11) begin
            step <= '0;
            if (VERIFY_EN) begin
              state     <= VERIFY;
              seq_read  <= 1'b1;
              seq_write <= 1'b0;
              seq_addr  <= 6'h00;
              seq_data  <= '0;
            end else if (AUTO_ENABLE) begin
              state     <= ENABLE;
              seq_addr  <= 6'h0C;
              seq_data  <= 8'h01;
            end else begin
              state     <= FIN;
              done      <= 1'b1;
              seq_read  <= 1'b0;
              seq_write <= 1'b0;
              seq_addr  <= '0;
              seq_data  <= '0;
            end
          end else begin
            step                 <= step_nxt;
            {seq_addr, seq_data} <= cfg_wr_nxt;
          end
        end
        VERIFY: begin
          if (mismatch) error <= 1'b1;
          if (step == 4'd8) begin
            step <= '0;
            // error is not yet updated for the final read, so fold it in here
            if (AUTO_ENABLE && !error && !mismatch) begin
              state     <= ENABLE;
              seq_read  <= 1'b0;
              seq_write <= 1'b1;
              seq_addr  <= 6'h0C;
              seq_data  <= 8'h01;
            end else begin
              state     <= FIN;
              done      <= 1'b1;
              seq_read  <= 1'b0;
              seq_write <= 1'b0;
              seq_addr  <= '0;
              seq_data  <= '0;
            end
          end else begin
            step     <= step_nxt;
            seq_addr <= vr_addr_nxt;
          end
        end
        ENABLE: begin
          if (step == 4'd0) begin
            step     <= 4'd1;
            seq_addr <= 6'h02;
            seq_data <= 8'h01;
          end else begin
            step      <= '0;
            state     <= FIN;
            done      <= 1'b1;
            seq_read  <= 1'b0;
            seq_write <= 1'b0;
            seq_addr  <= '0;
            seq_data  <= '0;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read           = busy ? seq_read  : host_read;
  assign write          = busy ? seq_write : host_write;
  assign addr           = busy ? seq_addr  : host_addr;
  assign data_write     = busy ? seq_data  : host_data_write;
  assign host_data_read = busy ? 8'h00     : data_read;
  assign host_stall     = busy & (host_read | host_write);

endmodule
